// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the radix-2 Booth multiplier.
package booth_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth partial-product step: conditional add/subtract of M, then
// arithmetic right shift of {A, Q, Q_1}.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH:0]   acc,
    input  logic        [WIDTH-1:0] q,
    input  logic                    q_1,
    input  logic signed [WIDTH-1:0] m,
    output logic signed [WIDTH:0]   acc_next,
    output logic        [WIDTH-1:0] q_next,
    output logic                    q_1_next
);

    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] sum;

    always_comb begin
        // one guard bit keeps A - M exact when M is the most negative value
        m_ext = {m[WIDTH-1], m};
        sum   = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed WIDTHxWIDTH Booth multiplier, one step per clock,
// start/done handshake with a registered 2*WIDTH product.
//
//  state   | meaning
//  --------+--------------------------------------------------
//  S_IDLE  | waiting for en; operands captured on accept
//  S_RUN   | one Booth step per edge, WIDTH steps total
//  S_DONE  | done pulse high for this cycle, product valid
module booth_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                      clkSys,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      done
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]              state;
    logic signed [WIDTH:0]   acc;
    logic [WIDTH-1:0]        q_reg;
    logic                    q_1;
    logic signed [WIDTH-1:0] m_reg;
    logic [CW-1:0]           count;

    logic signed [WIDTH:0]   acc_next;
    logic [WIDTH-1:0]        q_next;
    logic                    q_1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q_reg),
        .q_1      (q_1),
        .m        (m_reg),
        .acc_next (acc_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    // rst_n is an active-high synchronous reset despite its name
    always_ff @(posedge clkSys) begin
        if (rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        m_reg <= a;
                        q_reg <= b;
                        q_1   <= 1'b0;
                        acc   <= '0;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_1   <= q_1_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        product <= {acc_next[WIDTH-1:0], q_next};
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Directed and randomized checks of booth_mult against a plain 64-bit
// multiplication reference.
module tb_booth_mult;

    logic               clkSys = 1'b0;
    logic               rst_n  = 1'b1;
    logic               en     = 1'b0;
    logic signed [31:0] a      = '0;
    logic signed [31:0] b      = '0;
    logic signed [63:0] product;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

    booth_mult #(.WIDTH(32)) dut (
        .clkSys  (clkSys),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done)
    );

    always #5 clkSys = ~clkSys;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic signed [63:0] ref_mul(input logic signed [31:0] x, input logic signed [31:0] y);
        longint lx, ly;
        lx = x;
        ly = y;
        return lx * ly;
    endfunction

    // Caller sits #1 after a posedge. Issues (x,y); optionally pokes a second
    // en at edge k+busy_at or a reset at edge k+rst_at.
    task automatic do_op(input logic signed [31:0] x, input logic signed [31:0] y,
                         input int busy_at, input int rst_at, input string tag);
        logic signed [63:0] prev;
        int lat;
        int ndone;
        prev  = product;
        lat   = -1;
        ndone = 0;
        en = 1'b1;
        a  = x;
        b  = y;
        @(posedge clkSys); #1;
        en = 1'b0;
        a  = $urandom;
        b  = $urandom;
        for (int i = 1; i <= 36; i++) begin
            if (busy_at > 0 && i == busy_at) begin
                en = 1'b1;
                a  = x + 32'sd5;
                b  = y - 32'sd3;
            end
            if (rst_at > 0 && i == rst_at) rst_n = 1'b1;
            @(posedge clkSys); #1;
            en    = 1'b0;
            rst_n = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (i == 5) check64({tag, "_hold"}, product, prev);
        end
        if (rst_at > 0) begin
            check64({tag, "_ndone"}, 64'(ndone), 64'd0);
            check64({tag, "_prod"}, product, 64'd0);
        end else begin
            check64({tag, "_ndone"}, 64'(ndone), 64'd1);
            check64({tag, "_lat"}, 64'(lat), 64'd32);
            check64({tag, "_prod"}, product, ref_mul(x, y));
        end
    endtask

    initial begin
        logic signed [31:0] rx, ry;
        int ndone;

        repeat (3) @(posedge clkSys);
        #1;
        rst_n = 1'b0;
        check64("reset_prod", product, 64'd0);
        check64("reset_done", 64'(done), 64'd0);

        do_op(32'sd1,  -32'sd1,  0, 0, "s1");
        do_op(-32'sd2, -32'sd2,  0, 0, "s2");
        do_op(32'sd3,  -32'sd3,  0, 0, "s3");
        do_op(32'sd6,   32'sd6,  0, 0, "s4");
        do_op(-32'sd7, -32'sd7,  0, 0, "s5");
        do_op(32'sd10, -32'sd10, 0, 0, "s6");

        do_op(32'h8000_0000, 32'h8000_0000, 0, 0, "min_min");
        do_op(32'h8000_0000, 32'h7fff_ffff, 0, 0, "min_max");
        do_op(32'h7fff_ffff, 32'h7fff_ffff, 0, 0, "max_max");
        do_op(32'sd0, -32'sd5, 0, 0, "zero");

        do_op(32'sd1234, -32'sd77, 10, 0, "busy");

        do_op(32'sd55, 32'sd66, 0, 15, "abort");
        do_op(32'sd4, -32'sd4, 0, 0, "after_rst");

        // back-to-back at the earliest accept edge
        en = 1'b1; a = 32'sd8; b = -32'sd8;
        @(posedge clkSys); #1;
        en = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clkSys); #1;
            if (done) ndone++;
            if (i == 32) check64("b2b_first", product, ref_mul(32'sd8, -32'sd8));
        end
        check64("b2b_first_ndone", 64'(ndone), 64'd1);
        en = 1'b1; a = 32'sd9; b = -32'sd9;
        @(posedge clkSys); #1;
        en = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clkSys); #1;
            if (done) ndone++;
            if (i == 20) check64("b2b_hold", product, ref_mul(32'sd8, -32'sd8));
            if (i == 32) check64("b2b_second", product, ref_mul(32'sd9, -32'sd9));
        end
        check64("b2b_second_ndone", 64'(ndone), 64'd1);

        for (int r = 0; r < 20; r++) begin
            rx = $urandom;
            ry = $urandom;
            if (r % 5 == 1) rx = rx >>> 20;
            if (r % 5 == 2) ry = -ry;
            do_op(rx, ry, 0, 0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
